// File: rtl/ex_pkg.sv
// Shared types for the EX->MEM stage: beat payload, NZVC flags, skid FSM states.
// Datapath widths live here so the struct, interface and RTL stay in lockstep.
package ex_pkg;

  localparam int DATA_WIDTH = 64;
  localparam int REG_ADDR_W = 5;
  localparam int CTRL_W     = 4;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_C = 0;

  typedef struct packed {
    logic n;
    logic z;
    logic v;
    logic c;
  } flags_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] result;
    logic [REG_ADDR_W-1:0] dest;
    logic [CTRL_W-1:0]     ctrl;
  } ex_beat_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } skid_state_e;

  function automatic flags_t calc_flags(input logic [DATA_WIDTH-1:0] result,
                                        input logic ovf,
                                        input logic carry);
    flags_t f;
    f.n = result[DATA_WIDTH-1];
    f.z = (result == '0);
    f.v = ovf;
    f.c = carry;
    return f;
  endfunction

endpackage

// File: rtl/ex_mem_flag_stage_if.sv
// EX->MEM bus: upstream ALU beat, downstream MEM beat, flush and flag output.
// Handshake: a beat transfers on a rising edge where valid & ready are both high; valid
// never waits on ready, and a producer holds payload stable until the transfer happens.
interface ex_mem_flag_stage_if;

  logic                           in_valid;
  logic                           in_ready;
  logic [ex_pkg::DATA_WIDTH-1:0]  alu_result;
  logic                           alu_overflow;
  logic                           alu_carry_out;
  logic                           set_flags;
  logic [ex_pkg::REG_ADDR_W-1:0]  in_dest;
  logic [ex_pkg::CTRL_W-1:0]      in_ctrl;
  logic                           flush;
  logic                           out_valid;
  logic                           out_ready;
  logic [ex_pkg::DATA_WIDTH-1:0]  out_result;
  logic [ex_pkg::REG_ADDR_W-1:0]  out_dest;
  logic [ex_pkg::CTRL_W-1:0]      out_ctrl;
  logic [3:0]                     flags;

  modport master (
    output in_valid, alu_result, alu_overflow, alu_carry_out, set_flags,
           in_dest, in_ctrl, flush, out_ready,
    input  in_ready, out_valid, out_result, out_dest, out_ctrl, flags
  );

  modport slave (
    input  in_valid, alu_result, alu_overflow, alu_carry_out, set_flags,
           in_dest, in_ctrl, flush, out_ready,
    output in_ready, out_valid, out_result, out_dest, out_ctrl, flags
  );

endinterface

// File: rtl/skid_buffer_2.sv
// Two-entry skid buffer for ex_beat_t: 'main' drives the output, 'skid' catches the beat
// accepted while the head is stalled. in_ready is registered to break out_ready->in_ready.
module skid_buffer_2
  import ex_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        accept,
  input  ex_beat_t    in_beat,
  output logic        out_valid,
  input  logic        out_ready,
  output ex_beat_t    out_beat,
  output skid_state_e state
);

  skid_state_e state_q, state_d;
  logic        in_ready_q;
  ex_beat_t    main_q, skid_q;
  logic        do_release;
  logic        load_main_in, load_main_skid, load_skid;

  // A flushed cycle never accepts, so the presented beat is simply dropped.
  assign accept     = in_valid & in_ready_q & ~flush;
  assign do_release = (state_q != EMPTY) & out_ready;

  always_comb begin
    state_d        = state_q;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    case (state_q)
      EMPTY: if (accept) begin
        state_d      = ONE;
        load_main_in = 1'b1;
      end
      ONE: begin
        if (accept && !do_release) begin
          state_d   = TWO;
          load_skid = 1'b1;
        end else if (do_release && !accept) begin
          state_d = EMPTY;
        end else if (accept && do_release) begin
          load_main_in = 1'b1;
        end
      end
      TWO: if (do_release) begin
        state_d        = ONE;
        load_main_skid = 1'b1;
      end
      default: state_d = EMPTY;
    endcase
    if (flush) begin
      state_d        = EMPTY;
      load_main_in   = 1'b0;
      load_main_skid = 1'b0;
      load_skid      = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= EMPTY;
      in_ready_q <= 1'b1;
      main_q     <= '0;
      skid_q     <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != TWO);
      if (load_main_in)
        main_q <= in_beat;
      else if (load_main_skid)
        main_q <= skid_q;
      if (load_skid)
        skid_q <= in_beat;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = (state_q != EMPTY);
  assign out_beat  = main_q;
  assign state     = state_q;

endmodule

// File: rtl/ex_mem_flag_stage.sv
// EX->MEM pipeline register with 2-entry skid and the architectural NZVC flag register.
// FLAG_BYPASS_EN: flags shows the accepting set_flags beat's NZVC in the same cycle.
module ex_mem_flag_stage
  import ex_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  ex_mem_flag_stage_if.slave  bus,
  output skid_state_e         state
);

  ex_beat_t in_beat, out_beat;
  logic     accept;
  flags_t   flags_q, flags_in, flags_shown;

  assign in_beat = '{result: bus.alu_result, dest: bus.in_dest, ctrl: bus.in_ctrl};

  skid_buffer_2 u_skid (
    .clk       (clk),
    .reset     (reset),
    .flush     (bus.flush),
    .in_valid  (bus.in_valid),
    .in_ready  (bus.in_ready),
    .accept    (accept),
    .in_beat   (in_beat),
    .out_valid (bus.out_valid),
    .out_ready (bus.out_ready),
    .out_beat  (out_beat),
    .state     (state)
  );

  assign bus.out_result = out_beat.result;
  assign bus.out_dest   = out_beat.dest;
  assign bus.out_ctrl   = out_beat.ctrl;

  assign flags_in = calc_flags(bus.alu_result, bus.alu_overflow, bus.alu_carry_out);

  // Flags commit at accept, not at release: B.cond needs them as soon as SUBS leaves EX.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      flags_q <= '0;
    else if (accept && bus.set_flags)
      flags_q <= flags_in;
  end

`ifdef FLAG_BYPASS_EN
  assign flags_shown = (accept && bus.set_flags) ? flags_in : flags_q;
`else
  assign flags_shown = flags_q;
`endif

  assign bus.flags[FLAG_N] = flags_shown.n;
  assign bus.flags[FLAG_Z] = flags_shown.z;
  assign bus.flags[FLAG_V] = flags_shown.v;
  assign bus.flags[FLAG_C] = flags_shown.c;

endmodule

// File: tb/tb_ex_mem_flag_stage.sv
// Bench for ex_mem_flag_stage: vector table, hand corner sequences, random stream.
// Build with +define+FLAG_BYPASS_EN to exercise the same-cycle flag path.
module tb_ex_mem_flag_stage;
  import ex_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  ex_mem_flag_stage_if bus();
  skid_state_e state;

  ex_mem_flag_stage dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .state (state)
  );

  int n_vec = 0;
  int n_err = 0;
  bit rand_en = 1'b0;

  typedef struct {
    logic        sf;
    logic [63:0] res;
    logic        ovf;
    logic        cy;
    logic [4:0]  dest;
    logic [3:0]  ctrl;
    logic [3:0]  exp_flags;
  } vec_t;

  vec_t vt[8];

  logic [72:0] exp_q[$];
  logic [3:0]  exp_flags = 4'b0000;

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] model_flags(input logic [63:0] res, input logic ovf, input logic cy);
    return {res[63], (res == 64'd0), ovf, cy};
  endfunction

  // ---------------- scoreboard / monitor ----------------
  logic [72:0] mon_e;
  logic [3:0]  mon_f;
  logic        mon_acc;
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_beat: got %h expected none", bus.out_result);
        end else begin
          mon_e = exp_q.pop_front();
          check("out_beat", {bus.out_result, bus.out_dest, bus.out_ctrl}, mon_e);
        end
      end
      mon_acc = bus.in_valid && bus.in_ready && !bus.flush;
      mon_f = exp_flags;
`ifdef FLAG_BYPASS_EN
      if (mon_acc && bus.set_flags)
        mon_f = model_flags(bus.alu_result, bus.alu_overflow, bus.alu_carry_out);
`endif
      check("flags", bus.flags, mon_f);
      if (bus.flush)
        exp_q.delete();
      else if (mon_acc) begin
        exp_q.push_back({bus.alu_result, bus.in_dest, bus.in_ctrl});
        if (bus.set_flags)
          exp_flags = model_flags(bus.alu_result, bus.alu_overflow, bus.alu_carry_out);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_beat(input logic sf, input logic [63:0] res, input logic ovf,
                            input logic cy, input logic [4:0] dest, input logic [3:0] ctrl);
    bus.in_valid      = 1'b1;
    bus.set_flags     = sf;
    bus.alu_result    = res;
    bus.alu_overflow  = ovf;
    bus.alu_carry_out = cy;
    bus.in_dest       = dest;
    bus.in_ctrl       = ctrl;
  endtask

  task automatic send(input logic sf, input logic [63:0] res, input logic ovf,
                      input logic cy, input logic [4:0] dest, input logic [3:0] ctrl);
    int  cyc = 0;
    bit  done = 1'b0;
    drive_beat(sf, res, ovf, cy, dest, ctrl);
    while (!done) begin
      @(negedge clk);
      if (bus.in_ready && !bus.flush) done = 1'b1;
      @(posedge clk);
      #1;
      if (rand_en) bus.out_ready = 1'($urandom_range(0, 1));
      cyc++;
      if (!done && cyc > 50) begin
        check("send_timeout", 80'(cyc), 80'd0);
        done = 1'b1;
      end
    end
    bus.in_valid  = 1'b0;
    bus.set_flags = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (rand_en) bus.out_ready = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic drain();
    int c = 0;
    bus.out_ready = 1'b1;
    while (exp_q.size() != 0 && c < 100) begin
      @(posedge clk);
      #1;
      c++;
    end
    check("drain_empty", 80'(exp_q.size()), 80'd0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    bus.in_valid = 1'b0; bus.set_flags = 1'b0; bus.flush = 1'b0; bus.out_ready = 1'b0;
    bus.alu_result = '0; bus.alu_overflow = 1'b0; bus.alu_carry_out = 1'b0;
    bus.in_dest = '0; bus.in_ctrl = '0;

    vt[0] = '{1'b1, 64'h8000_0000_0000_0000, 1'b1, 1'b0, 5'd1,  4'h1, 4'b1010};
    vt[1] = '{1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 5'd2,  4'h2, 4'b0011};
    vt[2] = '{1'b0, 64'd8,                   1'b0, 1'b0, 5'd3,  4'h3, 4'b0011};
    vt[3] = '{1'b1, 64'd0,                   1'b0, 1'b1, 5'd4,  4'h4, 4'b0101};
    vt[4] = '{1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b1, 5'd5,  4'h5, 4'b1001};
    vt[5] = '{1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 5'd6,  4'h6, 4'b1000};
    vt[6] = '{1'b0, 64'd0,                   1'b1, 1'b1, 5'd7,  4'h7, 4'b1000};
    vt[7] = '{1'b1, 64'h8000_0000_0000_0000, 1'b1, 1'b0, 5'd31, 4'hF, 4'b1010};

    // reset state
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_flags", bus.flags, 4'b0000);
    check("rst_state", state, EMPTY);
    check("rst_out_result", bus.out_result, 0);
    @(posedge clk); #1;

    // vector table: one beat at a time, flags visible the cycle after accept
    bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      send(vt[i].sf, vt[i].res, vt[i].ovf, vt[i].cy, vt[i].dest, vt[i].ctrl);
      @(negedge clk);
      check("vec_out_valid", bus.out_valid, 1);
      check("vec_result", bus.out_result, vt[i].res);
      check("vec_flags", bus.flags, vt[i].exp_flags);
      @(posedge clk); #1;
    end
    drain();

    // backpressure: 5,6 fill both entries, 7 waits
    bus.out_ready = 1'b0;
    send(1'b0, 64'd5, 1'b0, 1'b0, 5'd5, 4'h5);
    send(1'b0, 64'd6, 1'b0, 1'b0, 5'd6, 4'h6);
    drive_beat(1'b0, 64'd7, 1'b0, 1'b0, 5'd7, 4'h7);
    @(negedge clk);
    check("two_state", state, TWO);
    check("two_in_ready", bus.in_ready, 0);
    check("two_head", bus.out_result, 64'd5);
    @(posedge clk); #1;
    check("two_head_stable", bus.out_result, 64'd5);
    bus.out_ready = 1'b1;
    send(1'b0, 64'd7, 1'b0, 1'b0, 5'd7, 4'h7);
    drain();

    // flush from TWO with a SUBS 9-9 presented
    bus.out_ready = 1'b0;
    send(1'b0, 64'd11, 1'b0, 1'b0, 5'd11, 4'hB);
    send(1'b0, 64'd12, 1'b0, 1'b0, 5'd12, 4'hC);
    drive_beat(1'b1, 64'd0, 1'b0, 1'b1, 5'd9, 4'h9);
    bus.flush = 1'b1;
    @(negedge clk);
    check("flush2_flags_same", bus.flags, 4'b1010);
    @(posedge clk); #1;
    bus.flush = 1'b0; bus.in_valid = 1'b0; bus.set_flags = 1'b0;
    @(negedge clk);
    check("flush2_state", state, EMPTY);
    check("flush2_out_valid", bus.out_valid, 0);
    check("flush2_in_ready", bus.in_ready, 1);
    check("flush2_flags", bus.flags, 4'b1010);
    @(posedge clk); #1;

    // flush from ONE: in_ready is high, beat must still be dropped
    send(1'b0, 64'd13, 1'b0, 1'b0, 5'd13, 4'hD);
    drive_beat(1'b1, 64'd0, 1'b0, 1'b1, 5'd9, 4'h9);
    bus.flush = 1'b1;
    @(negedge clk);
    check("flush1_flags_same", bus.flags, 4'b1010);
    @(posedge clk); #1;
    bus.flush = 1'b0; bus.in_valid = 1'b0; bus.set_flags = 1'b0;
    @(negedge clk);
    check("flush1_state", state, EMPTY);
    check("flush1_out_valid", bus.out_valid, 0);
    check("flush1_flags", bus.flags, 4'b1010);
    @(posedge clk); #1;

    // SUBS 10-10 followed by a B.cond probe
    bus.out_ready = 1'b1;
    drive_beat(1'b1, 64'd0, 1'b0, 1'b1, 5'd10, 4'hA);
`ifdef FLAG_BYPASS_EN
    @(negedge clk);
    check("bcond_accept_cycle", bus.flags, 4'b0101);
`else
    @(negedge clk);
    check("bcond_accept_cycle", bus.flags, 4'b1010);
`endif
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.set_flags = 1'b0;
    @(negedge clk);
    check("bcond_next_cycle", bus.flags, 4'b0101);
    @(posedge clk); #1;
    drain();

    // async reset pulse between clock edges
    bus.out_ready = 1'b0;
    send(1'b1, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 5'd1, 4'h1);
    send(1'b0, 64'd21, 1'b0, 1'b0, 5'd2, 4'h2);
    #2 reset = 1'b1;
    #1;
    check("areset_out_valid", bus.out_valid, 0);
    check("areset_in_ready", bus.in_ready, 1);
    check("areset_flags", bus.flags, 4'b0000);
    check("areset_out_result", bus.out_result, 0);
    reset = 1'b0;
    exp_q.delete();
    exp_flags = 4'b0000;
    @(posedge clk); #1;

    // random stream with random backpressure
    rand_en = 1'b1;
    for (int i = 0; i < 60; i++) begin
      send(1'($urandom_range(0, 1)), {$urandom, $urandom}, 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), 4'($urandom_range(0, 15)));
      if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
    end
    rand_en = 1'b0;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
